// File: rtl/gcd_pkg.sv
// Shared types and defaults for the subtract-based Euclid GCD engine.
package gcd_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_ITER_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/gcd_if.sv
// Operand and result handshakes between host, GCD engine and result consumer.
interface gcd_if
    import gcd_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ITER_W = DEF_ITER_W
) ();

    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  x_in;
    logic [WIDTH-1:0]  y_in;
    logic              abort;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  gcd_out;
    logic [ITER_W-1:0] iter_out;
    logic              zero_err;

    modport master (
        output in_valid, x_in, y_in, abort, out_ready,
        input  in_ready, out_valid, gcd_out, iter_out, zero_err
    );

    modport slave (
        input  in_valid, x_in, y_in, abort, out_ready,
        output in_ready, out_valid, gcd_out, iter_out, zero_err
    );

endinterface

// File: rtl/gcd_datapath.sv
// X/Y operand registers with comparator flags and one shared subtractor
// that always computes larger-minus-smaller.
module gcd_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             eq,
    output logic             lt,
    output logic             x_zero,
    output logic             y_zero
);

    logic [WIDTH-1:0] x_reg;
    logic [WIDTH-1:0] y_reg;
    logic [WIDTH-1:0] diff;

    assign eq     = (x_reg == y_reg);
    assign lt     = (x_reg < y_reg);
    assign x_zero = (x_reg == '0);
    assign y_zero = (y_reg == '0);

    // Operands swapped by lt so the result can never wrap.
    assign diff = lt ? (y_reg - x_reg) : (x_reg - y_reg);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_reg <= '0;
            y_reg <= '0;
        end else if (load) begin
            x_reg <= x_in;
            y_reg <= y_in;
        end else if (step) begin
            if (lt) begin
                y_reg <= diff;
            end else begin
                x_reg <= diff;
            end
        end
    end

    assign x = x_reg;
    assign y = y_reg;

endmodule

// File: rtl/gcd_engine.sv
// Euclid GCD engine: accepts an operand pair, subtracts until done and
// returns GCD, subtraction count and zero-operand flag with back-pressure.
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ITER_W = DEF_ITER_W
) (
    input logic  clk,
    input logic  reset,
    gcd_if.slave bus
);

    state_t            state_reg;
    logic [ITER_W-1:0] iter_reg;
    logic [WIDTH-1:0]  gcd_reg;
    logic [ITER_W-1:0] iter_out_reg;
    logic              zero_err_reg;
    logic              out_valid_reg;
    logic              in_ready_reg;

    logic [WIDTH-1:0]  x;
    logic [WIDTH-1:0]  y;
    logic              eq;
    logic              lt;
    logic              x_zero;
    logic              y_zero;
    logic              load;
    logic              step;

    assign load = (state_reg == ST_IDLE) && bus.in_valid && in_ready_reg;
    assign step = (state_reg == ST_CALC) && !bus.abort && !x_zero && !y_zero && !eq;

    gcd_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .step   (step),
        .x_in   (bus.x_in),
        .y_in   (bus.y_in),
        .x      (x),
        .y      (y),
        .eq     (eq),
        .lt     (lt),
        .x_zero (x_zero),
        .y_zero (y_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            iter_reg      <= '0;
            gcd_reg       <= '0;
            iter_out_reg  <= '0;
            zero_err_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (load) begin
                        iter_reg     <= '0;
                        zero_err_reg <= 1'b0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= ST_CALC;
                    end else begin
                        in_ready_reg <= 1'b1;
                    end
                end
                ST_CALC: begin
                    if (bus.abort) begin
                        in_ready_reg <= 1'b1;
                        state_reg    <= ST_IDLE;
                    end else if (x_zero || y_zero || eq) begin
                        // Covers 0/0 (gcd 0, flagged), one zero operand, and X==Y.
                        if (x_zero && y_zero) begin
                            gcd_reg      <= '0;
                            zero_err_reg <= 1'b1;
                        end else if (x_zero) begin
                            gcd_reg <= y;
                        end else begin
                            gcd_reg <= x;
                        end
                        iter_out_reg  <= iter_reg;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_DONE;
                    end else begin
                        iter_reg <= iter_reg + {{(ITER_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b0;
                    state_reg     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.gcd_out   = gcd_reg;
    assign bus.iter_out  = iter_out_reg;
    assign bus.zero_err  = zero_err_reg;

endmodule

// File: tb/tb_gcd_engine.sv
// Directed-vector bench for gcd_engine at WIDTH=8 and WIDTH=4.
module tb_gcd_engine;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    gcd_if #(.WIDTH(8), .ITER_W(8)) bus8 ();
    gcd_if #(.WIDTH(4), .ITER_W(4)) bus4 ();

    gcd_engine #(.WIDTH(8), .ITER_W(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
    gcd_engine #(.WIDTH(4), .ITER_W(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operand pair through the 8-bit engine; hold>0 stalls out_ready in DONE.
    task automatic run_op(input logic [7:0] xv, input logic [7:0] yv, input int eg,
                          input int ei, input int ez, input int hold);
        int w;
        int lat;
        bus8.out_ready = (hold == 0);
        w = 0;
        while (!bus8.in_ready && w < 10) begin
            tick();
            w++;
        end
        check("in_ready_idle", 32'(bus8.in_ready), 1);
        bus8.x_in     = xv;
        bus8.y_in     = yv;
        bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        check("in_ready_calc", 32'(bus8.in_ready), 0);
        lat = 0;
        while (!bus8.out_valid && lat < 1000) begin
            tick();
            lat++;
        end
        check("latency", lat, ei + 1);
        check("gcd_out", 32'(bus8.gcd_out), eg);
        check("iter_out", 32'(bus8.iter_out), ei);
        check("zero_err", 32'(bus8.zero_err), ez);
        for (int i = 0; i < hold; i++) begin
            bus8.in_valid = 1'b1;
            bus8.x_in     = 8'd3;
            bus8.y_in     = 8'd5;
            tick();
            check("hold_valid", 32'(bus8.out_valid), 1);
            check("hold_gcd", 32'(bus8.gcd_out), eg);
            check("hold_iter", 32'(bus8.iter_out), ei);
            check("hold_in_ready", 32'(bus8.in_ready), 0);
        end
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b1;
        tick();
        check("out_valid_after_hs", 32'(bus8.out_valid), 0);
        check("in_ready_after_hs", 32'(bus8.in_ready), 1);
        $display("op (%0d,%0d): gcd=%0d iter=%0d zero_err=%0d latency=%0d",
                 xv, yv, bus8.gcd_out, bus8.iter_out, bus8.zero_err, lat);
    endtask

    initial begin
        int cnt;
        int seen;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        bus8.in_valid = 1'b0; bus8.x_in = '0; bus8.y_in = '0; bus8.abort = 1'b0; bus8.out_ready = 1'b1;
        bus4.in_valid = 1'b0; bus4.x_in = '0; bus4.y_in = '0; bus4.abort = 1'b0; bus4.out_ready = 1'b1;

        repeat (3) tick();
        check("rst_out_valid", 32'(bus8.out_valid), 0);
        check("rst_gcd", 32'(bus8.gcd_out), 0);
        check("rst_iter", 32'(bus8.iter_out), 0);
        check("rst_zero_err", 32'(bus8.zero_err), 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("rst_in_ready_release", 32'(bus8.in_ready), 1);
        $display("reset released: in_ready=%0d", bus8.in_ready);

        // T1..T4
        run_op(8'd12, 8'd8, 4, 2, 0, 0);
        run_op(8'd255, 8'd1, 1, 254, 0, 0);
        run_op(8'd7, 8'd7, 7, 0, 0, 0);
        run_op(8'd0, 8'd9, 9, 0, 0, 0);
        run_op(8'd9, 8'd0, 9, 0, 0, 0);
        run_op(8'd0, 8'd0, 0, 0, 1, 0);
        run_op(8'd48, 8'd18, 6, 4, 0, 5);

        // T5: abort sampled on the 3rd CALC edge
        bus8.x_in = 8'd200; bus8.y_in = 8'd3; bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        tick();
        tick();
        bus8.abort = 1'b1;
        tick();
        bus8.abort = 1'b0;
        check("abort_in_ready", 32'(bus8.in_ready), 1);
        check("abort_out_valid", 32'(bus8.out_valid), 0);
        check("abort_gcd_held", 32'(bus8.gcd_out), 6);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus8.out_valid) seen++;
        end
        check("abort_no_result", seen, 0);
        $display("op (200,3) aborted: out_valid pulses=%0d", seen);
        run_op(8'd10, 8'd4, 2, 3, 0, 0);

        // T6: async reset mid-CALC
        bus8.x_in = 8'd200; bus8.y_in = 8'd3; bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        repeat (5) tick();
        #2;
        reset = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus8.out_valid), 0);
        check("arst_gcd", 32'(bus8.gcd_out), 0);
        check("arst_iter", 32'(bus8.iter_out), 0);
        check("arst_zero_err", 32'(bus8.zero_err), 0);
        check("arst_in_ready", 32'(bus8.in_ready), 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("arst_in_ready_release", 32'(bus8.in_ready), 1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus8.out_valid) seen++;
        end
        check("arst_discarded", seen, 0);
        $display("reset mid-CALC: pending result discarded, pulses=%0d", seen);
        run_op(8'd200, 8'd3, 1, 68, 0, 0);

        // WIDTH=4 instance: (15,6) -> 3 after 3 subtractions
        bus4.x_in = 4'd15; bus4.y_in = 4'd6; bus4.in_valid = 1'b1;
        tick();
        bus4.in_valid = 1'b0;
        cnt = 0;
        while (!bus4.out_valid && cnt < 100) begin
            tick();
            cnt++;
        end
        check("w4_latency", cnt, 4);
        check("w4_gcd", 32'(bus4.gcd_out), 3);
        check("w4_iter", 32'(bus4.iter_out), 3);
        check("w4_zero_err", 32'(bus4.zero_err), 0);
        tick();
        check("w4_out_valid_after_hs", 32'(bus4.out_valid), 0);
        $display("w4 op (15,6): gcd=%0d iter=%0d latency=%0d", bus4.gcd_out, bus4.iter_out, cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
